// File: rtl/cve2_rvfi_trace_fifo.sv
// Retirement trace FIFO: buffers RVFI records for a slow sink, counting and
// flagging retirements dropped while the buffer is full.
module cve2_rvfi_trace_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned LvlW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic            rvfi_valid,
  input  logic [31:0]     rvfi_pc_rdata,
  input  logic [31:0]     rvfi_insn,
  input  logic            rvfi_trap,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [31:0]     rvfi_rd_wdata,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [31:0]     trace_pc_o,
  output logic [31:0]     trace_insn_o,
  output logic [31:0]     trace_rd_wdata_o,
  output logic [4:0]      trace_rd_addr_o,
  output logic            trace_trap_o,
  output logic            trace_lost_o,
  output logic [15:0]     drop_count_o,
  output logic [LvlW-1:0] level_o
);
  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        lost;
  } rec_t;

  rec_t            mem_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [LvlW-1:0] level_q;
  logic [15:0]     drop_q;
  logic            lost_pend_q;

  logic retire, pop, push, drop;
  rec_t wrec, head;

  assign retire = rvfi_valid && enable_i && !clear_i;
  assign pop    = (level_q != '0) && trace_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push   = retire && ((level_q != FullLvl) || pop);
  assign drop   = retire && !push;

  always_comb begin
    wrec.pc       = rvfi_pc_rdata;
    wrec.insn     = rvfi_insn;
    wrec.trap     = rvfi_trap;
    wrec.rd_addr  = rvfi_rd_addr;
    wrec.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
    wrec.lost     = lost_pend_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      lost_pend_q <= 1'b0;
    end else if (clear_i) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      lost_pend_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      if (drop)      lost_pend_q <= 1'b1;
      else if (push) lost_pend_q <= 1'b0;
    end
  end

  // Record storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wrec;
  end

  assign head             = mem_q[rptr_q];
  assign trace_valid_o    = (level_q != '0);
  assign trace_pc_o       = head.pc;
  assign trace_insn_o     = head.insn;
  assign trace_rd_wdata_o = head.rd_wdata;
  assign trace_rd_addr_o  = head.rd_addr;
  assign trace_trap_o     = head.trap;
  assign trace_lost_o     = head.lost;
  assign drop_count_o     = drop_q;
  assign level_o          = level_q;
endmodule

// File: tb/tb_cve2_rvfi_trace_fifo.sv
// Directed bench for the RVFI trace FIFO: vector table plus multi-cycle sequences.
module tb_cve2_rvfi_trace_fifo;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        enable_i, clear_i, rvfi_valid, rvfi_trap, trace_ready_i;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic        trace_valid_o, trace_trap_o, trace_lost_o;
  logic [31:0] trace_pc_o, trace_insn_o, trace_rd_wdata_o;
  logic [4:0]  trace_rd_addr_o;
  logic [15:0] drop_count_o;
  logic [3:0]  level_o;

  int checks = 0, errors = 0;

  cve2_rvfi_trace_fifo #(.Depth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o),
    .trace_rd_wdata_o(trace_rd_wdata_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_trap_o(trace_trap_o), .trace_lost_o(trace_lost_o),
    .drop_count_o(drop_count_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        v, en, clr, rdy;
    logic [31:0] pc, insn;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        e_vld;
    logic [3:0]  e_lvl;
    logic [31:0] e_pc, e_insn, e_wd;
    logic        e_lost;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic clr, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] insn,
                       input logic [4:0] rd, input logic [31:0] wd);
    rvfi_valid = v; enable_i = en; clear_i = clr; trace_ready_i = rdy;
    rvfi_pc_rdata = pc; rvfi_insn = insn; rvfi_rd_addr = rd; rvfi_rd_wdata = wd;
    rvfi_trap = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] ppc;

    vecs[0] = '{"retire_basic", 1,1,0,1, 32'h100, 32'h00500093, 5'd1, 32'd5,
                1, 4'd1, 32'h100, 32'h00500093, 32'd5, 0, 16'd0};
    vecs[1] = '{"drain_basic", 0,1,0,1, 32'h0, 32'h0, 5'd0, 32'd0,
                0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 16'd0};
    vecs[2] = '{"rd0_zeroed", 1,1,0,0, 32'h200, 32'h00000013, 5'd0, 32'hDEADBEEF,
                1, 4'd1, 32'h200, 32'h00000013, 32'h0, 0, 16'd0};
    vecs[3] = '{"drain_rd0", 0,1,0,1, 32'h0, 32'h0, 5'd0, 32'd0,
                0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 16'd0};
    vecs[4] = '{"clear_with_valid", 1,1,1,0, 32'h300, 32'h1, 5'd3, 32'd7,
                0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 16'd0};
    vecs[5] = '{"disabled_retire", 1,0,0,0, 32'h400, 32'h2, 5'd4, 32'd9,
                0, 4'd0, 32'h0, 32'h0, 32'h0, 0, 16'd0};

    drive(0,1,0,0, 0,0,0,0);
    #12;
    chk("reset_valid", 32'(trace_valid_o), 32'd0);
    chk("reset_level", 32'(level_o), 32'd0);
    chk("reset_drop", 32'(drop_count_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].clr, vecs[i].rdy,
            vecs[i].pc, vecs[i].insn, vecs[i].rd, vecs[i].wd);
      step();
      chk({vecs[i].name, "_valid"}, 32'(trace_valid_o), 32'(vecs[i].e_vld));
      chk({vecs[i].name, "_level"}, 32'(level_o), 32'(vecs[i].e_lvl));
      chk({vecs[i].name, "_drop"}, 32'(drop_count_o), 32'(vecs[i].e_drop));
      if (vecs[i].e_vld) begin
        chk({vecs[i].name, "_pc"}, trace_pc_o, vecs[i].e_pc);
        chk({vecs[i].name, "_insn"}, trace_insn_o, vecs[i].e_insn);
        chk({vecs[i].name, "_wdata"}, trace_rd_wdata_o, vecs[i].e_wd);
        chk({vecs[i].name, "_lost"}, 32'(trace_lost_o), 32'(vecs[i].e_lost));
      end
    end

    // Overflow: 10 retirements into a stalled 8-deep FIFO drop the last two.
    for (int i = 0; i < 10; i++) begin
      drive(1,1,0,0, 32'h1000 + 32'(4*i), 32'h13, 5'(i+1), 32'(i));
      step();
    end
    chk("ovf_level", 32'(level_o), 32'd8);
    chk("ovf_drop", 32'(drop_count_o), 32'd2);
    chk("ovf_head_pc", trace_pc_o, 32'h1000);
    chk("ovf_head_lost", 32'(trace_lost_o), 32'd0);
    drive(1,1,0,1, 32'h1028, 32'h13, 5'd11, 32'd10);
    step();
    chk("ovf_pushpop_level", 32'(level_o), 32'd8);
    chk("ovf_pushpop_drop", 32'(drop_count_o), 32'd2);
    drive(0,1,0,1, 0,0,0,0);
    for (int k = 1; k < 8; k++) begin
      chk("ovf_order_pc", trace_pc_o, 32'h1000 + 32'(4*k));
      chk("ovf_order_lost", 32'(trace_lost_o), 32'd0);
      step();
    end
    chk("ovf_ninth_pc", trace_pc_o, 32'h1028);
    chk("ovf_ninth_lost", 32'(trace_lost_o), 32'd1);
    step();
    chk("ovf_empty_level", 32'(level_o), 32'd0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) begin
      drive(1,1,0,0, 32'h5000 + 32'(4*i), 32'h13, 5'd2, 32'(i));
      step();
    end
    chk("pre_rst_level", 32'(level_o), 32'd5);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 32'(trace_valid_o), 32'd0);
    chk("async_rst_level", 32'(level_o), 32'd0);
    chk("async_rst_drop", 32'(drop_count_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    drive(1,1,0,0, 32'h6000, 32'h13, 5'd3, 32'd33);
    step();
    chk("post_rst_push_level", 32'(level_o), 32'd1);
    chk("post_rst_push_pc", trace_pc_o, 32'h6000);
    chk("post_rst_push_lost", 32'(trace_lost_o), 32'd0);

    // Full FIFO with simultaneous push/pop across pointer wrap.
    drive(0,1,1,0, 0,0,0,0);
    step();
    for (int i = 0; i < 8; i++) begin
      ppc = 32'h2000 + 32'(4*i);
      drive(1,1,0,0, ppc, 32'h13, 5'd1, 32'(i));
      step();
      q.push_back(ppc);
    end
    chk("wrap_full_level", 32'(level_o), 32'd8);
    for (int j = 8; j < 20; j++) begin
      chk("wrap_head_pc", trace_pc_o, q[0]);
      ppc = 32'h2000 + 32'(4*j);
      drive(1,1,0,1, ppc, 32'h13, 5'd1, 32'(j));
      step();
      void'(q.pop_front());
      q.push_back(ppc);
      chk("wrap_level", 32'(level_o), 32'd8);
    end
    chk("wrap_no_drop", 32'(drop_count_o), 32'd0);
    drive(0,1,0,1, 0,0,0,0);
    while (q.size() > 0) begin
      chk("wrap_drain_pc", trace_pc_o, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("wrap_drained", 32'(level_o), 32'd0);

    // Drop counter saturation, then clear with a coincident retirement.
    for (int i = 0; i < 8; i++) begin
      drive(1,1,0,0, 32'h3000, 32'h13, 5'd1, 32'd1);
      step();
    end
    for (int i = 0; i < 65540; i++) step();
    chk("sat_drop", 32'(drop_count_o), 32'h0000FFFF);
    chk("sat_level", 32'(level_o), 32'd8);
    drive(1,1,1,0, 32'h3100, 32'h13, 5'd1, 32'd1);
    step();
    chk("clr_level", 32'(level_o), 32'd0);
    chk("clr_drop", 32'(drop_count_o), 32'd0);
    chk("clr_valid", 32'(trace_valid_o), 32'd0);
    drive(0,1,0,0, 0,0,0,0);
    step();
    chk("clr_no_record", 32'(level_o), 32'd0);
    drive(1,1,0,0, 32'h3200, 32'h13, 5'd1, 32'd1);
    step();
    chk("clr_lost_cleared", 32'(trace_lost_o), 32'd0);
    chk("clr_push_pc", trace_pc_o, 32'h3200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cve2_rvfi_trace_fifo.md
CVE2_RVFI_TRACE_FIFO -- requirements
Module: cve2_rvfi_trace_fifo

Interface
REQ-001: The block SHALL have parameter Depth, default 8, meaning the number of record entries; legal values are powers of two, 2..64.
REQ-002: The block SHALL have parameter LvlW, default $clog2(Depth+1), meaning the width of level_o.
REQ-003: clk_i  in  1  single clock; all state SHALL be clocked on the rising edge.
REQ-004: rst_ni  in  1  reset, asynchronous and active-low.
REQ-005: enable_i  in  1  capture enable; when low, RVFI retirements are ignored and not counted.
REQ-006: clear_i  in  1  synchronous flush of FIFO contents, the drop counter and the lost flag.
REQ-007: rvfi_valid  in  1  one instruction retires this cycle.
REQ-008: rvfi_pc_rdata  in  32  PC of the retiring instruction.
REQ-009: rvfi_insn  in  32  instruction word.
REQ-010: rvfi_trap  in  1  retirement trapped.
REQ-011: rvfi_rd_addr  in  5  destination register.
REQ-012: rvfi_rd_wdata  in  32  destination write data.
REQ-013: trace_valid_o  out  1  head record available.
REQ-014: trace_ready_i  in  1  sink accepts the head record.
REQ-015: trace_pc_o, trace_insn_o, trace_rd_wdata_o  out  32 each  head record fields.
REQ-016: trace_rd_addr_o  out  5; trace_trap_o  out  1  head record fields.
REQ-017: trace_lost_o  out  1  one or more records were dropped immediately before the head record.
REQ-018: drop_count_o  out  16  saturating count of dropped retirements.
REQ-019: level_o  out  LvlW  current occupancy, 0..Depth.

Function
REQ-020: Push condition: push SHALL occur when rvfi_valid && enable_i && !clear_i && (level<Depth || pop).
REQ-021: Pop condition: pop SHALL be defined as trace_valid_o && trace_ready_i.
REQ-022: Storage: a pushed record SHALL be stored as {pc, insn, trap, rd_addr, rd_wdata, lost}; when rd_addr==0, rd_wdata SHALL be stored as 0.
REQ-023: Ordering: the FIFO SHALL be first-word-fall-through, with outputs taken directly from the head entry.
REQ-024: Latency: a push in cycle N SHALL give trace_valid_o=1 in cycle N+1 when the FIFO was empty; there SHALL be no same-cycle bypass.
REQ-025: trace_valid_o SHALL equal (level_o!=0); while trace_valid_o=0 the data outputs are don't-care.
REQ-026: Once trace_valid_o=1, the head record SHALL remain stable until popped; pop on empty SHALL be impossible by construction.
REQ-027: Simultaneous push and pop SHALL leave level unchanged; at full, the freed slot SHALL be reused in the same cycle.
REQ-028: Pointers: read and write pointers SHALL be log2(Depth) bits wide, wrap modulo Depth, and be distinguished full/empty via level.
REQ-029: Drop event: rvfi_valid && enable_i && !clear_i && !push.
REQ-030: On a drop event, drop_count SHALL increment by 1, saturating at 0xFFFF, and lost_pending SHALL be set.
REQ-031: The next push SHALL store lost=lost_pending and clear lost_pending in the same cycle.
REQ-032: A drop and a push cannot coincide; the lost flag of a record SHALL never refer to drops occurring after that record.
REQ-033: clear_i SHALL win over push, pop and drop.
REQ-034: Next cycle after clear_i: level=0, pointers=0, drop_count=0, lost_pending=0.
REQ-035: A retirement coinciding with clear_i SHALL be discarded and not counted.
REQ-036: With enable_i=0, the FIFO SHALL continue to drain and drop_count and lost_pending SHALL hold.

Reset
REQ-037: Asynchronous assertion of rst_ni SHALL force trace_valid_o=0, level_o=0, drop_count_o=0, lost_pending=0, and pointers=0.
REQ-038: Reset SHALL act mid-operation and discard stored records; record storage need not be reset.
REQ-039: The first push SHALL be possible in the first clock edge after rst_ni deasserts.

Verification
REQ-040: Retire pc=0x100, insn=0x00500093, rd=1, wdata=5 into an empty FIFO with ready=1 -> trace_valid_o=1 one cycle later with those fields, lost=0, then level returns to 0.
REQ-041: Depth=8, ready=0, 10 consecutive retirements -> level_o=8, drop_count_o=2; then ready=1 and one more retirement -> that 9th popped record has lost=1 and all earlier records have lost=0.
REQ-042: FIFO full with push and pop in the same cycle -> level stays 8, no drop, and records emerge in order across pointer wrap.
REQ-043: Retire rd=0 with wdata=0xDEADBEEF -> trace_rd_wdata_o=0.
REQ-044: 0x10000 drops -> drop_count_o holds at 0xFFFF; clear_i coinciding with rvfi_valid -> level 0, count 0, and no record stored.
REQ-045: Assert rst_ni low mid-burst with level=5 -> trace_valid_o=0 and level_o=0 immediately, without waiting for a clock edge.
